// File: rtl/br_station_multi_if.sv
// Issue / CDB / resolved-PC bundle for br_station_multi.
// BR_THREAD_FLUSH_EN adds the per-thread flush request.
interface br_station_multi_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int TID_W = 1
);
  logic             stall_i;
  logic             issue_en;
  logic [XLEN-1:0]  issue_v1, issue_v2;
  logic             issue_v1_rdy, issue_v2_rdy;
  logic [TAG_W-1:0] issue_q1, issue_q2;
  logic [TID_W-1:0] issue_tid;
  logic [2:0]       issue_op;
  logic [XLEN-1:0]  issue_pc, issue_offset;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_value;
  logic             pc_ack;
  logic             full_o, fifo_empty;
  logic [XLEN-1:0]  pc_n;
  logic [TID_W-1:0] thread_id;
`ifdef BR_THREAD_FLUSH_EN
  logic             flush_i;
  logic [TID_W-1:0] flush_tid;
`endif

  modport master (
`ifdef BR_THREAD_FLUSH_EN
    output flush_i, flush_tid,
`endif
    output stall_i, issue_en, issue_v1, issue_v2, issue_v1_rdy, issue_v2_rdy,
           issue_q1, issue_q2, issue_tid, issue_op, issue_pc, issue_offset,
           cdb_valid, cdb_tag, cdb_value, pc_ack,
    input  full_o, fifo_empty, pc_n, thread_id
  );

  modport slave (
`ifdef BR_THREAD_FLUSH_EN
    input  flush_i, flush_tid,
`endif
    input  stall_i, issue_en, issue_v1, issue_v2, issue_v1_rdy, issue_v2_rdy,
           issue_q1, issue_q2, issue_tid, issue_op, issue_pc, issue_offset,
           cdb_valid, cdb_tag, cdb_value, pc_ack,
    output full_o, fifo_empty, pc_n, thread_id
  );
endinterface

// File: rtl/br_station_multi.sv
// Multi-entry branch reservation station with CDB snoop and a show-ahead resolved-PC FIFO.
// Optional macro BR_THREAD_FLUSH_EN enables per-thread flush of waiting entries.
module br_station_multi #(
  parameter int XLEN       = 32,
  parameter int RS_DEPTH   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 4,
  parameter int THREADS    = 2,
  parameter int TID_W      = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input logic              clk,
  input logic              rst,
  br_station_multi_if.slave bus
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FDEPTH = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic             busy;
    logic [XLEN-1:0]  v1, v2;
    logic             r1, r2;
    logic [TAG_W-1:0] q1, q2;
    logic [TID_W-1:0] tid;
    logic [2:0]       op;
    logic [XLEN-1:0]  pc, off;
  } ent_t;

  typedef struct packed {
    logic [TID_W-1:0] tid;
    logic [XLEN-1:0]  pc;
  } res_t;

  ent_t [RS_DEPTH-1:0]   ent_q, ent_d;
  res_t [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  full_q, full_d, empty_q, empty_d;

  logic                  flush_v;
  logic [TID_W-1:0]      flush_tid_v;
`ifdef BR_THREAD_FLUSH_EN
  assign flush_v     = bus.flush_i;
  assign flush_tid_v = bus.flush_tid;
`else
  assign flush_v     = 1'b0;
  assign flush_tid_v = '0;
`endif

  logic             sel_found, free_found, do_res, do_iss, push, pop, taken;
  logic [IDX_W-1:0] sel_idx, free_idx;
  ent_t             sel, new_ent;
  logic [XLEN-1:0]  npc;

  always_comb begin
    ent_d      = ent_q;
    mem_d      = mem_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    taken      = 1'b0;
    new_ent    = '0;

    // Wakeup runs regardless of stall so operands are never lost.
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (ent_q[i].busy && bus.cdb_valid) begin
        if (!ent_q[i].r1 && ent_q[i].q1 == bus.cdb_tag) begin
          ent_d[i].v1 = bus.cdb_value;
          ent_d[i].r1 = 1'b1;
        end
        if (!ent_q[i].r2 && ent_q[i].q2 == bus.cdb_tag) begin
          ent_d[i].v2 = bus.cdb_value;
          ent_d[i].r2 = 1'b1;
        end
      end
    end

    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!sel_found && ent_q[i].busy && ent_q[i].r1 && ent_q[i].r2 &&
          !(flush_v && ent_q[i].tid == flush_tid_v)) begin
        sel_found = 1'b1;
        sel_idx   = i[IDX_W-1:0];
      end
      if (!free_found && !ent_q[i].busy) begin
        free_found = 1'b1;
        free_idx   = i[IDX_W-1:0];
      end
    end

    sel    = ent_q[sel_idx];
    do_res = sel_found && !bus.stall_i && (cnt_q < FDEPTH);
    unique case (sel.op)
      3'b000:  taken = sel.v1 == sel.v2;
      3'b001:  taken = sel.v1 != sel.v2;
      3'b100:  taken = $signed(sel.v1) <  $signed(sel.v2);
      3'b101:  taken = $signed(sel.v1) >= $signed(sel.v2);
      3'b110:  taken = sel.v1 <  sel.v2;
      3'b111:  taken = sel.v1 >= sel.v2;
      default: taken = 1'b0;
    endcase
    npc = taken ? sel.pc + sel.off : sel.pc + XLEN'(4);
    if (do_res) ent_d[sel_idx].busy = 1'b0;

    for (int i = 0; i < RS_DEPTH; i++)
      if (flush_v && ent_q[i].tid == flush_tid_v) ent_d[i].busy = 1'b0;

    // full_q tracks &busy_q, so a free slot always exists when issue is taken.
    do_iss = bus.issue_en && !full_q && !bus.stall_i &&
             !(flush_v && bus.issue_tid == flush_tid_v);
    new_ent.busy = 1'b1;
    new_ent.r1   = bus.issue_v1_rdy || (bus.cdb_valid && bus.issue_q1 == bus.cdb_tag);
    new_ent.r2   = bus.issue_v2_rdy || (bus.cdb_valid && bus.issue_q2 == bus.cdb_tag);
    new_ent.v1   = bus.issue_v1_rdy ? bus.issue_v1 : bus.cdb_value;
    new_ent.v2   = bus.issue_v2_rdy ? bus.issue_v2 : bus.cdb_value;
    new_ent.q1   = bus.issue_q1;
    new_ent.q2   = bus.issue_q2;
    new_ent.tid  = bus.issue_tid;
    new_ent.op   = bus.issue_op;
    new_ent.pc   = bus.issue_pc;
    new_ent.off  = bus.issue_offset;
    if (do_iss) ent_d[free_idx] = new_ent;

    full_d = 1'b1;
    for (int i = 0; i < RS_DEPTH; i++) full_d = full_d & ent_d[i].busy;

    push = do_res;
    pop  = bus.pc_ack && !empty_q;
    if (push) begin
      mem_d[wr_q] = '{tid: sel.tid, pc: npc};
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) rd_d = rd_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      ent_q   <= ent_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign bus.full_o     = full_q;
  assign bus.fifo_empty = empty_q;
  assign bus.pc_n       = empty_q ? '0 : mem_q[rd_q].pc;
  assign bus.thread_id  = empty_q ? '0 : mem_q[rd_q].tid;
endmodule

// File: tb/tb_br_station_multi.sv
// Scoreboard bench for br_station_multi: expected next-PCs queued at stimulus, checked at FIFO head.
module tb_br_station_multi;
  localparam int XLEN = 32, RS_DEPTH = 4, FIFO_DEPTH = 4, TAG_W = 4, THREADS = 2, TID_W = 1;
  localparam logic [2:0] BEQ = 3'b000, BNE = 3'b001, BLT = 3'b100, BGE = 3'b101,
                         BLTU = 3'b110, BGEU = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  br_station_multi_if #(.XLEN(XLEN), .TAG_W(TAG_W), .TID_W(TID_W)) bus ();
  br_station_multi #(.XLEN(XLEN), .RS_DEPTH(RS_DEPTH), .FIFO_DEPTH(FIFO_DEPTH),
                     .TAG_W(TAG_W), .THREADS(THREADS), .TID_W(TID_W))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [TID_W-1:0] tid;
    logic [XLEN-1:0]  pc;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [XLEN-1:0] model_npc(input logic [2:0] op,
      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
      input logic [XLEN-1:0] pc, input logic [XLEN-1:0] off);
    logic t;
    case (op)
      BEQ:     t = (a == b);
      BNE:     t = (a != b);
      BLT:     t = ($signed(a) < $signed(b));
      BGE:     t = ($signed(a) >= $signed(b));
      BLTU:    t = (a < b);
      BGEU:    t = (a >= b);
      default: t = 1'b0;
    endcase
    return t ? pc + off : pc + 32'd4;
  endfunction

  task automatic idle_inputs();
    bus.stall_i = 0; bus.issue_en = 0; bus.issue_v1 = 0; bus.issue_v2 = 0;
    bus.issue_v1_rdy = 0; bus.issue_v2_rdy = 0; bus.issue_q1 = 0; bus.issue_q2 = 0;
    bus.issue_tid = 0; bus.issue_op = 0; bus.issue_pc = 0; bus.issue_offset = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_value = 0; bus.pc_ack = 0;
`ifdef BR_THREAD_FLUSH_EN
    bus.flush_i = 0; bus.flush_tid = 0;
`endif
  endtask

  // One-cycle issue request; a not-ready operand waits on tag q.
  task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] v1, input logic r1,
      input logic [XLEN-1:0] v2, input logic r2, input logic [TAG_W-1:0] q,
      input logic [XLEN-1:0] pc, input logic [XLEN-1:0] off, input logic [TID_W-1:0] tid);
    bus.issue_en = 1; bus.issue_op = op; bus.issue_v1 = v1; bus.issue_v1_rdy = r1;
    bus.issue_v2 = v2; bus.issue_v2_rdy = r2; bus.issue_q1 = q; bus.issue_q2 = q;
    bus.issue_pc = pc; bus.issue_offset = off; bus.issue_tid = tid;
    @(negedge clk);
    bus.issue_en = 0;
  endtask

  // Compare FIFO head with scoreboard front, then pop it with a one-cycle pc_ack.
  task automatic expect_head(input string nm, input int max_wait);
    exp_t e;
    int n;
    n = 0;
    while (bus.fifo_empty && n < max_wait) begin @(negedge clk); n++; end
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: unexpected state, scoreboard empty (pc_n=%h)", nm, bus.pc_n);
    end else if (bus.fifo_empty) begin
      e = sb.pop_front();
      miscompares++;
      $display("FAIL %s: no result after %0d cycles, required tid=%0d pc_n=%h", nm, n, e.tid, e.pc);
    end else begin
      e = sb.pop_front();
      if ({bus.thread_id, bus.pc_n} !== e) begin
        miscompares++;
        $display("FAIL %s: got tid=%0d pc_n=%h, required tid=%0d pc_n=%h",
                 nm, bus.thread_id, bus.pc_n, e.tid, e.pc);
      end
      bus.pc_ack = 1;
      @(negedge clk);
      bus.pc_ack = 0;
    end
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    vectors++; if (bus.full_o !== 1'b0)     begin miscompares++; $display("FAIL reset_full: got %b required 0", bus.full_o); end
    vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b required 1", bus.fifo_empty); end
    vectors++; if (bus.pc_n !== '0)         begin miscompares++; $display("FAIL reset_pc_n: got %h required 0", bus.pc_n); end
    vectors++; if (bus.thread_id !== '0)    begin miscompares++; $display("FAIL reset_tid: got %0d required 0", bus.thread_id); end
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_beq();
    issue(BEQ, 32'd256, 1, 32'd256, 1, 0, 32'h100, 32'h40, 1'b1);
    sb.push_back('{tid: 1'b1, pc: model_npc(BEQ, 32'd256, 32'd256, 32'h100, 32'h40)});
    vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL beq_early: fifo_empty got %b required 1", bus.fifo_empty); end
    @(negedge clk);
    vectors++; if (bus.fifo_empty !== 1'b0) begin miscompares++; $display("FAIL beq_latency: fifo_empty got %b required 0", bus.fifo_empty); end
    expect_head("beq_result", 0);
    vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL beq_pop: fifo_empty got %b required 1", bus.fifo_empty); end
  endtask

  task automatic test_signed_unsigned();
    issue(BLT,  32'hFFFF_FFFF, 1, 32'd1, 1, 0, 32'h200, 32'h20, 1'b0);
    issue(BLTU, 32'hFFFF_FFFF, 1, 32'd1, 1, 0, 32'h200, 32'h20, 1'b0);
    sb.push_back('{tid: 1'b0, pc: model_npc(BLT,  32'hFFFF_FFFF, 32'd1, 32'h200, 32'h20)});
    sb.push_back('{tid: 1'b0, pc: model_npc(BLTU, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h20)});
    expect_head("blt_signed", 0);
    expect_head("bltu_unsigned", 0);
    issue(BGEU, 32'h8000_0000, 1, 32'd5, 1, 0, 32'hFFFF_FFF0, 32'h20, 1'b1);
    sb.push_back('{tid: 1'b1, pc: model_npc(BGEU, 32'h8000_0000, 32'd5, 32'hFFFF_FFF0, 32'h20)});
    expect_head("bgeu_wrap", 1);
    issue(3'b010, 32'd1, 1, 32'd1, 1, 0, 32'h700, 32'h40, 1'b0);
    sb.push_back('{tid: 1'b0, pc: 32'h704});
    expect_head("funct3_010", 1);
  endtask

  task automatic test_wakeup();
    issue(BNE, 32'd256, 1, 32'd0, 0, 4'd10, 32'h300, 32'h80, 1'b0);
    bus.cdb_valid = 1; bus.cdb_tag = 4'd7; bus.cdb_value = 32'd128;
    @(negedge clk);
    bus.cdb_valid = 0;
    repeat (3) @(negedge clk);
    vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL wrong_tag: fifo_empty got %b required 1", bus.fifo_empty); end
    bus.cdb_valid = 1; bus.cdb_tag = 4'd10; bus.cdb_value = 32'd128;
    sb.push_back('{tid: 1'b0, pc: model_npc(BNE, 32'd256, 32'd128, 32'h300, 32'h80)});
    @(negedge clk);
    bus.cdb_valid = 0;
    @(negedge clk);
    expect_head("cdb_wakeup", 0);
    bus.cdb_valid = 1; bus.cdb_tag = 4'd10; bus.cdb_value = 32'd256;
    issue(BNE, 32'd256, 1, 32'd0, 0, 4'd10, 32'h400, 32'h10, 1'b1);
    bus.cdb_valid = 0;
    sb.push_back('{tid: 1'b1, pc: model_npc(BNE, 32'd256, 32'd256, 32'h400, 32'h10)});
    @(negedge clk);
    expect_head("cdb_forward", 0);
  endtask

  task automatic test_full_and_fifo();
    for (int k = 0; k < RS_DEPTH; k++)
      issue(BEQ, XLEN'(k), 1, 32'd0, 0, 4'd3, 32'h1000 + XLEN'(k * 16), 32'h100, TID_W'(k));
    vectors++; if (bus.full_o !== 1'b1) begin miscompares++; $display("FAIL rs_full: full_o got %b required 1", bus.full_o); end
    issue(BEQ, 32'd5, 1, 32'd5, 1, 0, 32'h9000, 32'h4, 1'b0);
    vectors++; if (bus.full_o !== 1'b1) begin miscompares++; $display("FAIL rs_full_hold: full_o got %b required 1", bus.full_o); end
    bus.cdb_valid = 1; bus.cdb_tag = 4'd3; bus.cdb_value = 32'd2;
    for (int k = 0; k < RS_DEPTH; k++)
      sb.push_back('{tid: TID_W'(k), pc: model_npc(BEQ, XLEN'(k), 32'd2, 32'h1000 + XLEN'(k * 16), 32'h100)});
    @(negedge clk);
    bus.cdb_valid = 0;
    repeat (6) @(negedge clk);
    vectors++; if (bus.full_o !== 1'b0) begin miscompares++; $display("FAIL rs_drained: full_o got %b required 0", bus.full_o); end
    issue(BEQ, 32'd7, 1, 32'd7, 1, 0, 32'h2000, 32'h8, 1'b1);
    sb.push_back('{tid: 1'b1, pc: model_npc(BEQ, 32'd7, 32'd7, 32'h2000, 32'h8)});
    repeat (4) @(negedge clk);
    for (int k = 0; k <= RS_DEPTH; k++) expect_head("fifo_order", 10);
    repeat (3) @(negedge clk);
    vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL dropped_issue: fifo_empty got %b required 1", bus.fifo_empty); end
  endtask

  task automatic test_stall();
    issue(BGE, 32'd3, 1, 32'd0, 0, 4'd5, 32'h600, 32'h40, 1'b1);
    bus.stall_i = 1;
    bus.cdb_valid = 1; bus.cdb_tag = 4'd5; bus.cdb_value = 32'd3;
    @(negedge clk);
    bus.cdb_valid = 0;
    issue(BEQ, 32'd1, 1, 32'd1, 1, 0, 32'h500, 32'h20, 1'b0);
    repeat (3) @(negedge clk);
    vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL stall_hold: fifo_empty got %b required 1", bus.fifo_empty); end
    bus.stall_i = 0;
    sb.push_back('{tid: 1'b1, pc: model_npc(BGE, 32'd3, 32'd3, 32'h600, 32'h40)});
    @(negedge clk);
    expect_head("stall_release", 0);
    repeat (3) @(negedge clk);
    vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL stall_drop: fifo_empty got %b required 1", bus.fifo_empty); end
  endtask

  task automatic test_reset_mid_and_empty_ack();
    issue(BEQ, 32'd1, 1, 32'd1, 1, 0, 32'h800, 32'h10, 1'b0);
    issue(BEQ, 32'd1, 1, 32'd1, 1, 0, 32'h900, 32'h10, 1'b1);
    rst = 0;
    @(negedge clk);
    rst = 1;
    vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL mid_reset_empty: got %b required 1", bus.fifo_empty); end
    vectors++; if (bus.pc_n !== '0)         begin miscompares++; $display("FAIL mid_reset_pc_n: got %h required 0", bus.pc_n); end
    repeat (4) @(negedge clk);
    vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL mid_reset_discard: fifo_empty got %b required 1", bus.fifo_empty); end
    bus.pc_ack = 1;
    @(negedge clk);
    bus.pc_ack = 0;
    vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL empty_ack: fifo_empty got %b required 1", bus.fifo_empty); end
    issue(BNE, 32'd1, 1, 32'd2, 1, 0, 32'hA00, 32'h30, 1'b1);
    sb.push_back('{tid: 1'b1, pc: model_npc(BNE, 32'd1, 32'd2, 32'hA00, 32'h30)});
    @(negedge clk);
    expect_head("after_empty_ack", 0);
    vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL after_empty_ack_pop: fifo_empty got %b required 1", bus.fifo_empty); end
  endtask

`ifdef BR_THREAD_FLUSH_EN
  task automatic test_flush();
    issue(BEQ, 32'd1, 1, 32'd0, 0, 4'd6, 32'hB00, 32'h10, 1'b0);
    issue(BEQ, 32'd1, 1, 32'd0, 0, 4'd6, 32'hB10, 32'h10, 1'b0);
    issue(BEQ, 32'd1, 1, 32'd0, 0, 4'd6, 32'hC00, 32'h10, 1'b1);
    bus.flush_i = 1; bus.flush_tid = 1'b0;
    @(negedge clk);
    bus.flush_i = 0;
    bus.cdb_valid = 1; bus.cdb_tag = 4'd6; bus.cdb_value = 32'd1;
    sb.push_back('{tid: 1'b1, pc: model_npc(BEQ, 32'd1, 32'd1, 32'hC00, 32'h10)});
    @(negedge clk);
    bus.cdb_valid = 0;
    expect_head("flush_survivor", 10);
    repeat (4) @(negedge clk);
    vectors++; if (bus.fifo_empty !== 1'b1) begin miscompares++; $display("FAIL flush_removed: fifo_empty got %b required 1", bus.fifo_empty); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_beq();
    test_signed_unsigned();
    test_wakeup();
    test_full_and_fifo();
    test_stall();
    test_reset_mid_and_empty_ack();
`ifdef BR_THREAD_FLUSH_EN
    test_flush();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
